// File: rtl/nasti_lite_pkg.sv
// Shared definitions for the nasti-lite write arbiter: FSM state encoding and
// B response codes.
package nasti_lite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

endpackage : nasti_lite_pkg

// File: rtl/nasti_lite_write_arbiter_if.sv
// Bus bundle for the write arbiter: N master-side lite write ports plus the
// single slave-side port. The slave modport is the arbiter's view.
interface nasti_lite_write_arbiter_if #(
  parameter int N_MASTER   = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(N_MASTER);
  localparam int SID_W = IDX_W + ID_WIDTH;

  // Every channel uses valid/ready: a beat transfers on a rising clk edge where
  // both are high; a source holds valid and payload stable until that edge.
  logic [N_MASTER-1:0][ID_WIDTH-1:0]     s_aw_id;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]   s_aw_addr;
  logic [N_MASTER-1:0]                   s_aw_valid;
  logic [N_MASTER-1:0]                   s_aw_ready;

  logic [N_MASTER-1:0][DATA_WIDTH-1:0]   s_w_data;
  logic [N_MASTER-1:0][DATA_WIDTH/8-1:0] s_w_strb;
  logic [N_MASTER-1:0]                   s_w_valid;
  logic [N_MASTER-1:0]                   s_w_ready;

  logic [ID_WIDTH-1:0]                   s_b_id;
  logic [1:0]                            s_b_resp;
  logic [N_MASTER-1:0]                   s_b_valid;
  logic [N_MASTER-1:0]                   s_b_ready;

  logic [SID_W-1:0]                      m_aw_id;
  logic [ADDR_WIDTH-1:0]                 m_aw_addr;
  logic                                  m_aw_valid;
  logic                                  m_aw_ready;

  logic [DATA_WIDTH-1:0]                 m_w_data;
  logic [DATA_WIDTH/8-1:0]               m_w_strb;
  logic                                  m_w_valid;
  logic                                  m_w_ready;

  logic [SID_W-1:0]                      m_b_id;
  logic [1:0]                            m_b_resp;
  logic                                  m_b_valid;
  logic                                  m_b_ready;

  modport slave (
    input  s_aw_id, s_aw_addr, s_aw_valid, output s_aw_ready,
    input  s_w_data, s_w_strb, s_w_valid,  output s_w_ready,
    output s_b_id, s_b_resp, s_b_valid,    input  s_b_ready,
    output m_aw_id, m_aw_addr, m_aw_valid, input  m_aw_ready,
    output m_w_data, m_w_strb, m_w_valid,  input  m_w_ready,
    input  m_b_id, m_b_resp, m_b_valid,    output m_b_ready
  );

  modport master (
    output s_aw_id, s_aw_addr, s_aw_valid, input  s_aw_ready,
    output s_w_data, s_w_strb, s_w_valid,  input  s_w_ready,
    input  s_b_id, s_b_resp, s_b_valid,    output s_b_ready,
    input  m_aw_id, m_aw_addr, m_aw_valid, output m_aw_ready,
    input  m_w_data, m_w_strb, m_w_valid,  output m_w_ready,
    output m_b_id, m_b_resp, m_b_valid,    input  m_b_ready
  );

endinterface : nasti_lite_write_arbiter_if

// File: rtl/nasti_lite_write_arbiter_rr.sv
// lite_rr_arbiter: picks the first requester found scanning upward from ptr
// (wrapping), returning a one-hot grant and its index. ptr = 0 gives fixed priority.
module lite_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int  idx;
    logic found;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IDX_W'(idx);
      end
    end
  end

endmodule : lite_rr_arbiter

// File: rtl/nasti_lite_write_arbiter.sv
// N-to-1 nasti-lite write arbiter: serialises AW+W per granted master, routes B
// by the master index in the upper ID bits. Define NASTI_LITE_WARB_ROUND_ROBIN_EN
// for round-robin arbitration; otherwise the lowest requesting index wins.
module nasti_lite_write_arbiter
  import nasti_lite_pkg::*;
#(
  parameter int N_MASTER   = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  nasti_lite_write_arbiter_if.slave   bus,
  output logic                        err_bad_bid,
  output state_e                      dbg_state
);

  localparam int IDX_W = $clog2(N_MASTER);
  localparam int SID_W = IDX_W + ID_WIDTH;

  if (N_MASTER < 2) begin : g_bad_n
    $fatal(1, "nasti_lite_write_arbiter: N_MASTER must be >= 2");
  end
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $fatal(1, "nasti_lite_write_arbiter: DATA_WIDTH must be 32 or 64");
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     g_q;
  logic [IDX_W-1:0]     ptr;
  logic [N_MASTER-1:0]  grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 load_g;
  logic                 w_done;
  logic                 err_q;

  lite_rr_arbiter #(.N(N_MASTER), .IDX_W(IDX_W)) u_arb (
    .req       (bus.s_aw_valid),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

`ifdef NASTI_LITE_WARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (w_done) begin
      ptr_q <= (g_q == IDX_W'(N_MASTER - 1)) ? '0 : g_q + IDX_W'(1);
    end
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load_g) g_q <= grant_idx;
    end
  end

  // Payload always follows g_q; only valid/ready are gated by state.
  always_comb begin
    state_d        = state_q;
    load_g         = 1'b0;
    w_done         = 1'b0;
    bus.s_aw_ready = '0;
    bus.s_w_ready  = '0;
    bus.m_aw_valid = 1'b0;
    bus.m_w_valid  = 1'b0;
    bus.m_aw_id    = {g_q, bus.s_aw_id[g_q]};
    bus.m_aw_addr  = bus.s_aw_addr[g_q];
    bus.m_w_data   = bus.s_w_data[g_q];
    bus.m_w_strb   = bus.s_w_strb[g_q];
    case (state_q)
      ST_IDLE: begin
        if (|grant_oh) begin
          load_g  = 1'b1;
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        bus.m_aw_valid      = bus.s_aw_valid[g_q];
        bus.s_aw_ready[g_q] = bus.m_aw_ready;
        if (bus.s_aw_valid[g_q] && bus.m_aw_ready) state_d = ST_W;
      end
      ST_W: begin
        bus.m_w_valid      = bus.s_w_valid[g_q];
        bus.s_w_ready[g_q] = bus.m_w_ready;
        if (bus.s_w_valid[g_q] && bus.m_w_ready) begin
          w_done  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // B path is purely combinational; an unknown master index is sunk.
  logic [IDX_W-1:0] b_idx;
  logic             b_in_range;

  always_comb begin
    b_idx         = bus.m_b_id[SID_W-1 -: IDX_W];
    b_in_range    = (int'(b_idx) < N_MASTER);
    bus.s_b_id    = bus.m_b_id[ID_WIDTH-1:0];
    bus.s_b_resp  = bus.m_b_resp;
    bus.s_b_valid = '0;
    bus.m_b_ready = 1'b1;
    if (b_in_range) begin
      bus.s_b_valid[b_idx] = bus.m_b_valid;
      bus.m_b_ready        = bus.s_b_ready[b_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (bus.m_b_valid && !b_in_range) begin
      err_q <= 1'b1;
    end
  end

  assign err_bad_bid = err_q;
  assign dbg_state   = state_q;

endmodule : nasti_lite_write_arbiter
